// File: rtl/conv_window_sequencer.sv
// Convolution window sequencer: walks every KxK window of an IMG_W x IMG_H image,
// issuing image/kernel read addresses for an external MAC and handing each finished
// window result downstream with a valid/ready handshake.
module conv_window_sequencer #(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28,
    parameter int unsigned K     = 5,
    localparam int unsigned OW   = IMG_W - K + 1,
    localparam int unsigned OH   = IMG_H - K + 1,
    localparam int unsigned AW   = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1,
    localparam int unsigned KW   = (K * K > 1) ? $clog2(K * K) : 1,
    localparam int unsigned OAW  = (OW * OH > 1) ? $clog2(OW * OH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic [AW-1:0]  pix_addr,
    output logic [KW-1:0]  ker_addr,
    output logic           mac_clr,
    output logic           mac_en,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OAW-1:0] out_addr
);

    // Counter widths; each is at least one bit so degenerate sizes still elaborate.
    localparam int unsigned XW  = (OW > 1) ? $clog2(OW) : 1;
    localparam int unsigned YW  = (OH > 1) ? $clog2(OH) : 1;
    localparam int unsigned KCW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StMac,
        StWrite,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [XW-1:0]  ox_q, ox_d;
    logic [YW-1:0]  oy_q, oy_d;
    logic [KCW-1:0] kx_q, kx_d;
    logic [KCW-1:0] ky_q, ky_d;

    logic kx_last, ky_last, ox_last, oy_last;

    // Carry-out of each wrap-at-stop counter.
    always_comb begin
        kx_last = (kx_q == KCW'(K - 1));
        ky_last = (ky_q == KCW'(K - 1));
        ox_last = (ox_q == XW'(OW - 1));
        oy_last = (oy_q == YW'(OH - 1));
    end

    // Address generation, purely combinational from the current counters.
    always_comb begin
        pix_addr = (AW'(oy_q) + AW'(ky_q)) * AW'(IMG_W) + AW'(ox_q) + AW'(kx_q);
        ker_addr = KW'(ky_q) * KW'(K) + KW'(kx_q);
        out_addr = OAW'(oy_q) * OAW'(OW) + OAW'(ox_q);
    end

    // Next-state, counter advance and control strobes.
    always_comb begin
        state_d   = state_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        kx_d      = kx_q;
        ky_d      = ky_q;
        busy      = (state_q != StIdle);
        done      = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                    ox_d    = '0;
                    oy_d    = '0;
                    kx_d    = '0;
                    ky_d    = '0;
                end
            end
            StClear: begin
                mac_clr = 1'b1;
                state_d = StMac;
            end
            StMac: begin
                mac_en = 1'b1;
                if (kx_last) begin
                    kx_d = '0;
                    if (ky_last) begin
                        ky_d    = '0;
                        state_d = StWrite;
                    end else begin
                        ky_d = ky_q + KCW'(1);
                    end
                end else begin
                    kx_d = kx_q + KCW'(1);
                end
            end
            StWrite: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (ox_last && oy_last) begin
                        // Last window: park the position counters at zero.
                        ox_d    = '0;
                        oy_d    = '0;
                        state_d = StDone;
                    end else begin
                        state_d = StClear;
                        if (ox_last) begin
                            ox_d = '0;
                            oy_d = oy_q + YW'(1);
                        end else begin
                            ox_d = ox_q + XW'(1);
                        end
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything else, including the handshake and counter advances.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            ox_d    = '0;
            oy_d    = '0;
            kx_d    = '0;
            ky_d    = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ox_q    <= '0;
            oy_q    <= '0;
            kx_q    <= '0;
            ky_q    <= '0;
        end else begin
            state_q <= state_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            kx_q    <= kx_d;
            ky_q    <= ky_d;
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed/randomized bench for conv_window_sequencer: a small 4x4/K=3 instance is
// checked cycle by cycle against window arithmetic, a default 28x28/K=5 instance
// is checked for handshake count, per-window MAC/clear counts and done latency.
module tb_conv_window_sequencer;

    logic clk;
    logic rst;

    // Small instance (4x4 image, K=3): AW=4, KW=4, OAW=2.
    logic       s_start, s_abort, s_busy, s_done, s_mac_clr, s_mac_en;
    logic       s_out_valid, s_out_ready;
    logic [3:0] s_pix;
    logic [3:0] s_ker;
    logic [1:0] s_out_addr;

    // Default instance (28x28 image, K=5): AW=10, KW=5, OAW=10.
    logic       b_start, b_abort, b_busy, b_done, b_mac_clr, b_mac_en;
    logic       b_out_valid, b_out_ready;
    logic [9:0] b_pix;
    logic [4:0] b_ker;
    logic [9:0] b_out_addr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    conv_window_sequencer #(
        .IMG_W(4),
        .IMG_H(4),
        .K    (3)
    ) u_small (
        .clk      (clk),
        .rst      (rst),
        .start    (s_start),
        .abort    (s_abort),
        .busy     (s_busy),
        .done     (s_done),
        .pix_addr (s_pix),
        .ker_addr (s_ker),
        .mac_clr  (s_mac_clr),
        .mac_en   (s_mac_en),
        .out_valid(s_out_valid),
        .out_ready(s_out_ready),
        .out_addr (s_out_addr)
    );

    conv_window_sequencer u_big (
        .clk      (clk),
        .rst      (rst),
        .start    (b_start),
        .abort    (b_abort),
        .busy     (b_busy),
        .done     (b_done),
        .pix_addr (b_pix),
        .ker_addr (b_ker),
        .mac_clr  (b_mac_clr),
        .mac_en   (b_mac_en),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .out_addr (b_out_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends.
    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish, observed running, required finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling happens 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One pass on the small instance. stallN = cycles out_ready is held low in window N;
    // abort_win/abort_idx select a MAC cycle to abort on (-1 for none).
    task automatic small_pass(input int stall0, input int stall1, input int stall2,
                              input int stall3, input int abort_win, input int abort_idx,
                              input bit poke);
        int stall[4];
        int w0_pix[9];
        int w3_pix[9];
        int total;
        int win;
        stall  = '{stall0, stall1, stall2, stall3};
        w0_pix = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        w3_pix = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        total  = stall0 + stall1 + stall2 + stall3;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        cyc = 1;
        for (int oy = 0; oy < 2; oy++) begin
            for (int ox = 0; ox < 2; ox++) begin
                win = oy * 2 + ox;
                chk("clr_pulse", s_mac_clr, 1);
                chk("clr_busy", s_busy, 1);
                chk("clr_en", s_mac_en, 0);
                chk("clr_valid", s_out_valid, 0);
                step();
                for (int i = 0; i < 9; i++) begin
                    chk("mac_en", s_mac_en, 1);
                    chk("mac_clr", s_mac_clr, 0);
                    chk("mac_valid", s_out_valid, 0);
                    chk("pix_addr", s_pix, (oy + i / 3) * 4 + ox + i % 3);
                    chk("ker_addr", s_ker, i);
                    if (win == 0) chk("pix_tbl_w0", s_pix, w0_pix[i]);
                    if (win == 3) chk("pix_tbl_w3", s_pix, w3_pix[i]);
                    if (win == abort_win && i == abort_idx) begin
                        s_abort = 1'b1;
                        step();
                        s_abort = 1'b0;
                        chk("abort_busy", s_busy, 0);
                        chk("abort_en", s_mac_en, 0);
                        for (int j = 0; j < 5; j++) begin
                            chk("abort_nodone", s_done, 0);
                            chk("abort_idle", s_busy, 0);
                            step();
                        end
                        return;
                    end
                    if (poke) s_start = 1'($urandom_range(0, 1));
                    step();
                    s_start = 1'b0;
                end
                for (int s = 0; s <= stall[win]; s++) begin
                    chk("wr_valid", s_out_valid, 1);
                    chk("wr_addr", s_out_addr, win);
                    chk("wr_en", s_mac_en, 0);
                    chk("wr_clr", s_mac_clr, 0);
                    s_out_ready = (s == stall[win]);
                    step();
                    s_out_ready = 1'b0;
                end
            end
        end
        chk("done_pulse", s_done, 1);
        chk("done_lat", cyc, 45 + total);
        chk("done_valid", s_out_valid, 0);
        step();
        chk("done_1cyc", s_done, 0);
        chk("idle_busy", s_busy, 0);
    endtask

    initial begin
        int run;
        int clr;
        int hs;
        rst = 1'b1;
        s_start = 1'b0; s_abort = 1'b0; s_out_ready = 1'b0;
        b_start = 1'b0; b_abort = 1'b0; b_out_ready = 1'b0;
        #3;
        chk("rst_busy", s_busy, 0);
        chk("rst_done", s_done, 0);
        chk("rst_clr", s_mac_clr, 0);
        chk("rst_en", s_mac_en, 0);
        chk("rst_valid", s_out_valid, 0);
        chk("rst_big_busy", b_busy, 0);
        chk("rst_big_valid", b_out_valid, 0);
        #20;
        rst = 1'b0;
        step();

        // Idle with no start.
        for (int i = 0; i < 3; i++) begin
            chk("idle_wait", s_busy, 0);
            step();
        end

        // Plain pass, then a long stall in window 1.
        small_pass(0, 0, 0, 0, -1, -1, 1'b0);
        small_pass(0, 7, 0, 0, -1, -1, 1'b0);

        // Random stalls with start poked while busy.
        small_pass($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), -1, -1, 1'b1);

        // Abort during window 2 MAC, then a fresh pass from window 0.
        small_pass(0, 0, 0, 0, 2, $urandom_range(0, 8), 1'b0);
        small_pass($urandom_range(0, 2), 0, $urandom_range(0, 2), 0, -1, -1, 1'b0);

        // Reset asserted while waiting in WRITE.
        s_out_ready = 1'b0;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        for (int i = 0; i < 30 && s_out_valid !== 1'b1; i++) step();
        chk("reach_write", s_out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", s_out_valid, 0);
        chk("arst_busy", s_busy, 0);
        chk("arst_en", s_mac_en, 0);
        chk("arst_clr", s_mac_clr, 0);
        chk("arst_done", s_done, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_busy", s_busy, 0);
            chk("post_rst_done", s_done, 0);
        end
        small_pass(0, 0, 0, 0, -1, -1, 1'b0);

        // Default-size instance, out_ready held high.
        b_out_ready = 1'b1;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        cyc = 1;
        run = 0;
        clr = 0;
        hs = 0;
        while (b_done !== 1'b1 && cyc < 20000) begin
            if (b_mac_clr === 1'b1) clr++;
            if (b_mac_en === 1'b1) run++;
            if (b_out_valid === 1'b1) begin
                chk("big_mac_cnt", run, 25);
                chk("big_clr_cnt", clr, 1);
                chk("big_addr", b_out_addr, hs);
                hs++;
                run = 0;
                clr = 0;
            end
            step();
        end
        chk("big_hs", hs, 576);
        chk("big_done", b_done, 1);
        chk("big_done_lat", cyc, 576 * 27 + 1);
        step();
        chk("big_idle", b_busy, 0);
        chk("big_done_1cyc", b_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
